baccarat_multi_ctrl: RTL and testbench
======================================

BACCARAT_MULTI_CTRL -- requirements
Module: baccarat_multi_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PLAYERS, default 2, giving the number of player hands, legal range 1..4.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each statistics counter.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset; all state SHALL update on the rising edge of slow_clock.
REQ-004 Port slow_clock  in  1  round-stepping clock.
REQ-005 Port resetb  in  1  asynchronous active-low reset.
REQ-006 Port new_round  in  1  request to start a round, sampled in S_IDLE and S_DONE.
REQ-007 Port dscore  in  4  dealer score (0..9) from the datapath.
REQ-008 Port pscore  in  4*NUM_PLAYERS  player scores; player i occupies bits [4i+3:4i].
REQ-009 Port pcard3  in  4*NUM_PLAYERS  third-card value of each player, packed as pscore.
REQ-010 Ports load_pcard1, load_pcard2, load_pcard3  out  NUM_PLAYERS each  per-player card-load strobes.
REQ-011 Ports load_dcard1, load_dcard2, load_dcard3  out  1 each  dealer card-load strobes.
REQ-012 Ports player_win_light, dealer_win_light  out  NUM_PLAYERS each  per-hand result lights; both set means tie.
REQ-013 Port busy  out  1  high in every state except S_IDLE and S_DONE.
REQ-014 Port round_cnt  out  CNT_W  completed-round count.
REQ-015 Port player_win_cnt  out  CNT_W*NUM_PLAYERS  per-player win count, packed as pscore.

Function
REQ-016 States SHALL be S_IDLE, S_P1, S_D1, S_P2, S_D2, S_P3, S_DDEC, S_D3, S_SCORE, S_DONE; idx is a player index counter.
REQ-017 S_IDLE and S_DONE SHALL go to S_P1 with idx=0 when new_round=1, and SHALL hold otherwise.
REQ-018 S_P1, S_P2 and S_P3 SHALL each last NUM_PLAYERS cycles with idx = 0..N-1, one cycle per player.
REQ-019 In S_P1 and S_P2, load_pcard1[idx] and load_pcard2[idx] SHALL be high respectively; S_D1 and S_D2 SHALL each last one cycle with load_dcard1 and load_dcard2 high respectively.
REQ-020 Path out of S_D2:
  - dscore>=8 (dealer natural): next state SHALL be S_SCORE.
  - otherwise: next state SHALL be S_P3.
  - in both cases, p0_two = pscore[3:0] SHALL be registered on exit from S_D2.
REQ-021 In S_P3, load_pcard3[idx] SHALL be high iff pscore of player idx <= 5; a player holding 6..9 stands, and no strobe is issued for that cycle.
REQ-022 S_DDEC SHALL last one cycle and go to S_D3 if the dealer draws, else to S_SCORE.
REQ-023 The dealer draw decision SHALL use lead player 0 only:
  - p0_two >= 8: dealer SHALL NOT draw.
  - p0_two 6..7: dealer SHALL draw iff dscore <= 5.
  - p0_two <= 5: dealer SHALL draw iff dscore <= 2; or dscore==3 and pcard3[0]!=8; or dscore==4 and pcard3[0] in 2..7; or dscore==5 and pcard3[0] in 4..7; or dscore==6 and pcard3[0] in 6..7.
REQ-024 S_D3 SHALL last one cycle with load_dcard3 high, then go to S_SCORE.
REQ-025 S_SCORE SHALL last one cycle and register results for each player i:
  - pscore_i > dscore: win light only.
  - pscore_i < dscore: dealer light only.
  - pscore_i == dscore: both lights.
REQ-026 In S_SCORE, round_cnt and each winning player's player_win_cnt SHALL increment, saturating at all-ones.
REQ-027 Result lights SHALL be held through S_DONE and SHALL clear on the cycle the FSM leaves S_DONE.
REQ-028 At most one load strobe SHALL be high in any cycle, and all strobes SHALL be low in S_IDLE, S_DDEC, S_SCORE and S_DONE.
REQ-029 new_round SHALL be ignored while busy=1.
REQ-030 Score inputs 10..15 SHALL be treated as stand (no draw) and compared numerically.
REQ-031 Latency from new_round in S_IDLE to S_DONE SHALL be 3N+5 cycles with the dealer drawing, 3N+4 without, and 2N+3 on a dealer natural.

Reset
REQ-032 resetb=0 SHALL asynchronously force S_IDLE and idx=0, and clear all strobes, lights, counters, p0_two and busy.
REQ-033 Reset asserted mid-round SHALL abandon the round without incrementing any counter.

Structure
REQ-034 Package baccarat_pkg SHALL hold the state enum and the constants NATURAL_MIN=8 and PLAYER_DRAW_MAX=5.
REQ-035 The third-card table of REQ-023 SHALL be a combinational sub-module baccarat_dealer_rule.

Verification
REQ-036 The bench SHALL cover these scenarios:
  - N=2, dscore=9 after S_D2 -> no load_pcard3 or load_dcard3; S_DONE after 7 cycles.
  - N=2, pscore={7,4}, p0_two=4, pcard3[0]=3, dscore=4 -> load_pcard3 only for player 0; dealer draws; S_DONE after 11 cycles.
  - N=1, p0_two=6, dscore=6 -> no third cards; tie; both lights on; round_cnt=1, player_win_cnt=0.
  - CNT_W=2, player 0 wins 5 rounds -> player_win_cnt[1:0] saturates at 3.
  - resetb pulsed low during S_P3 -> outputs zero immediately; counters unchanged from 0.
  - new_round pulsed during S_P2 -> ignored; sequence and timing unchanged.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared state encoding and drawing-rule constants for the multi-hand baccarat controller.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_P1, S_D1, S_P2, S_D2, S_P3, S_DDEC, S_D3, S_SCORE, S_DONE
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

  function automatic logic player_draws(input logic [3:0] score);
    return score <= PLAYER_DRAW_MAX;
  endfunction

endpackage

// File: rtl/baccarat_dealer_rule.sv
// Dealer third-card decision, driven by the lead player's two-card total and third card.
module baccarat_dealer_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] p0_two,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  // Lead player 6..7 means the lead stood; 0..5 means the lead drew and pcard3 matters.
  always_comb begin
    draw = 1'b0;
    if (p0_two >= NATURAL_MIN) begin
      draw = 1'b0;
    end else if (p0_two > PLAYER_DRAW_MAX) begin
      draw = (dscore <= PLAYER_DRAW_MAX);
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:    draw = (pcard3 != 4'd8);
        4'd4:    draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
        4'd5:    draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
        4'd6:    draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
        default: draw = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/baccarat_multi_ctrl.sv
// Round sequencer for one dealer and NUM_PLAYERS player hands, with result lights and
// saturating round / per-player win statistics.
module baccarat_multi_ctrl
  import baccarat_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CNT_W       = 8
) (
  input  logic                         slow_clock,
  input  logic                         resetb,
  input  logic                         new_round,
  input  logic [3:0]                   dscore,
  input  logic [4*NUM_PLAYERS-1:0]     pscore,
  input  logic [4*NUM_PLAYERS-1:0]     pcard3,
  output logic [NUM_PLAYERS-1:0]       load_pcard1,
  output logic [NUM_PLAYERS-1:0]       load_pcard2,
  output logic [NUM_PLAYERS-1:0]       load_pcard3,
  output logic                         load_dcard1,
  output logic                         load_dcard2,
  output logic                         load_dcard3,
  output logic [NUM_PLAYERS-1:0]       player_win_light,
  output logic [NUM_PLAYERS-1:0]       dealer_win_light,
  output logic                         busy,
  output logic [CNT_W-1:0]             round_cnt,
  output logic [CNT_W*NUM_PLAYERS-1:0] player_win_cnt
);

  localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAYERS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [3:0]       p0_two;
  logic [3:0]       next_score;
  logic             dealer_draw;

  function automatic logic [NUM_PLAYERS-1:0] one_hot(input logic [IDX_W-1:0] i);
    return NUM_PLAYERS'(1) << i;
  endfunction

  function automatic logic [3:0] score_of(input logic [4*NUM_PLAYERS-1:0] scores,
                                          input logic [IDX_W-1:0]         i);
    score_of = scores[3:0];
    for (int k = 0; k < NUM_PLAYERS; k++)
      if (IDX_W'(k) == i) score_of = scores[4*k +: 4];
  endfunction

  assign idx_next   = idx + 1'b1;
  assign next_score = score_of(pscore, idx_next);

  baccarat_dealer_rule u_dealer_rule (
    .p0_two (p0_two),
    .dscore (dscore),
    .pcard3 (pcard3[3:0]),
    .draw   (dealer_draw)
  );

  // Strobes are registered together with the state they belong to, so each transition
  // also loads the strobe pattern of the state being entered.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state            <= S_IDLE;
      idx              <= '0;
      p0_two           <= '0;
      busy             <= 1'b0;
      load_pcard1      <= '0;
      load_pcard2      <= '0;
      load_pcard3      <= '0;
      load_dcard1      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_dcard3      <= 1'b0;
      player_win_light <= '0;
      dealer_win_light <= '0;
      round_cnt        <= '0;
      player_win_cnt   <= '0;
    end else begin
      load_pcard1 <= '0;
      load_pcard2 <= '0;
      load_pcard3 <= '0;
      load_dcard1 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_dcard3 <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (new_round) begin
            state            <= S_P1;
            idx              <= '0;
            busy             <= 1'b1;
            load_pcard1      <= one_hot('0);
            player_win_light <= '0;
            dealer_win_light <= '0;
          end
        end
        S_P1: begin
          if (idx == LAST_IDX) begin
            state       <= S_D1;
            idx         <= '0;
            load_dcard1 <= 1'b1;
          end else begin
            idx         <= idx_next;
            load_pcard1 <= one_hot(idx_next);
          end
        end
        S_D1: begin
          state       <= S_P2;
          idx         <= '0;
          load_pcard2 <= one_hot('0);
        end
        S_P2: begin
          if (idx == LAST_IDX) begin
            state       <= S_D2;
            idx         <= '0;
            load_dcard2 <= 1'b1;
          end else begin
            idx         <= idx_next;
            load_pcard2 <= one_hot(idx_next);
          end
        end
        S_D2: begin
          p0_two <= pscore[3:0];
          idx    <= '0;
          if (dscore >= NATURAL_MIN) begin
            state <= S_SCORE;
          end else begin
            state       <= S_P3;
            load_pcard3 <= player_draws(pscore[3:0]) ? one_hot('0) : '0;
          end
        end
        S_P3: begin
          if (idx == LAST_IDX) begin
            state <= S_DDEC;
            idx   <= '0;
          end else begin
            idx         <= idx_next;
            load_pcard3 <= player_draws(next_score) ? one_hot(idx_next) : '0;
          end
        end
        S_DDEC: begin
          if (dealer_draw) begin
            state       <= S_D3;
            load_dcard3 <= 1'b1;
          end else begin
            state <= S_SCORE;
          end
        end
        S_D3: state <= S_SCORE;
        S_SCORE: begin
          state <= S_DONE;
          busy  <= 1'b0;
          if (round_cnt != '1) round_cnt <= round_cnt + 1'b1;
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            player_win_light[i] <= (pscore[4*i +: 4] >= dscore);
            dealer_win_light[i] <= (pscore[4*i +: 4] <= dscore);
            if ((pscore[4*i +: 4] > dscore) && (player_win_cnt[CNT_W*i +: CNT_W] != '1))
              player_win_cnt[CNT_W*i +: CNT_W] <= player_win_cnt[CNT_W*i +: CNT_W] + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baccarat_multi_ctrl.sv
// Directed bench: a two-player instance with default counters and a one-player instance
// with 2-bit counters, checked against hand-computed round traces.
module tb_baccarat_multi_ctrl;

  logic slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  logic        resetb_a, new_round_a;
  logic [3:0]  dscore_a;
  logic [7:0]  pscore_a, pcard3_a;
  logic [1:0]  lp1_a, lp2_a, lp3_a, pwl_a, dwl_a;
  logic        ld1_a, ld2_a, ld3_a, busy_a;
  logic [7:0]  rc_a;
  logic [15:0] pwc_a;

  logic        resetb_b, new_round_b;
  logic [3:0]  dscore_b, pscore_b, pcard3_b;
  logic [0:0]  lp1_b, lp2_b, lp3_b, pwl_b, dwl_b;
  logic        ld1_b, ld2_b, ld3_b, busy_b;
  logic [1:0]  rc_b, pwc_b;

  int n_vec = 0;
  int n_miss = 0;
  int lat, n_p3_0, n_p3_1, n_d3, n_strobe, n_multi;
  logic [3:0] first_lights;

  baccarat_multi_ctrl #(.NUM_PLAYERS(2), .CNT_W(8)) dut_a (
    .slow_clock(slow_clock), .resetb(resetb_a), .new_round(new_round_a),
    .dscore(dscore_a), .pscore(pscore_a), .pcard3(pcard3_a),
    .load_pcard1(lp1_a), .load_pcard2(lp2_a), .load_pcard3(lp3_a),
    .load_dcard1(ld1_a), .load_dcard2(ld2_a), .load_dcard3(ld3_a),
    .player_win_light(pwl_a), .dealer_win_light(dwl_a), .busy(busy_a),
    .round_cnt(rc_a), .player_win_cnt(pwc_a)
  );

  baccarat_multi_ctrl #(.NUM_PLAYERS(1), .CNT_W(2)) dut_b (
    .slow_clock(slow_clock), .resetb(resetb_b), .new_round(new_round_b),
    .dscore(dscore_b), .pscore(pscore_b), .pcard3(pcard3_b),
    .load_pcard1(lp1_b), .load_pcard2(lp2_b), .load_pcard3(lp3_b),
    .load_dcard1(ld1_b), .load_dcard2(ld2_b), .load_dcard3(ld3_b),
    .player_win_light(pwl_b), .dealer_win_light(dwl_b), .busy(busy_b),
    .round_cnt(rc_b), .player_win_cnt(pwc_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One round on dut_a; tallies strobes per busy cycle and optionally pokes new_round in S_P2.
  task automatic applyStimulus(input logic [3:0] ds, input logic [7:0] ps,
                               input logic [7:0] pc3, input bit stray);
    int hot;
    dscore_a = ds; pscore_a = ps; pcard3_a = pc3;
    lat = 0; n_p3_0 = 0; n_p3_1 = 0; n_d3 = 0; n_strobe = 0; n_multi = 0;
    first_lights = 4'hf;
    @(negedge slow_clock); new_round_a = 1'b1;
    @(negedge slow_clock); new_round_a = 1'b0;
    while (busy_a && lat < 40) begin
      lat++;
      hot = $countones({lp1_a, lp2_a, lp3_a, ld1_a, ld2_a, ld3_a});
      n_strobe += hot;
      if (hot > 1) n_multi++;
      if (lat == 1) first_lights = {pwl_a, dwl_a};
      n_p3_0 += int'(lp3_a[0]);
      n_p3_1 += int'(lp3_a[1]);
      n_d3   += int'(ld3_a);
      new_round_a = (stray && lp2_a != 2'b00);
      @(negedge slow_clock);
    end
    new_round_a = 1'b0;
  endtask

  task automatic verifyRound(input string tag, input int e_lat, input int e_p3_0,
                             input int e_p3_1, input int e_d3, input logic [1:0] e_pwl,
                             input logic [1:0] e_dwl, input logic [7:0] e_rc,
                             input logic [15:0] e_pwc);
    checkOutput({tag, "/latency"}, lat, e_lat);
    checkOutput({tag, "/pcard3_p0"}, n_p3_0, e_p3_0);
    checkOutput({tag, "/pcard3_p1"}, n_p3_1, e_p3_1);
    checkOutput({tag, "/dcard3"}, n_d3, e_d3);
    checkOutput({tag, "/strobe_total"}, n_strobe, 6 + e_p3_0 + e_p3_1 + e_d3);
    checkOutput({tag, "/multi_hot"}, n_multi, 0);
    checkOutput({tag, "/lights_cleared"}, first_lights, 0);
    checkOutput({tag, "/done_strobes"},
                $countones({lp1_a, lp2_a, lp3_a, ld1_a, ld2_a, ld3_a}), 0);
    checkOutput({tag, "/player_light"}, pwl_a, e_pwl);
    checkOutput({tag, "/dealer_light"}, dwl_a, e_dwl);
    checkOutput({tag, "/round_cnt"}, rc_a, e_rc);
    checkOutput({tag, "/win_cnt"}, pwc_a, e_pwc);
  endtask

  task automatic runRoundB(input logic [3:0] ds, input logic [3:0] ps);
    dscore_b = ds; pscore_b = ps; pcard3_b = 4'd0;
    @(negedge slow_clock); new_round_b = 1'b1;
    @(negedge slow_clock); new_round_b = 1'b0;
    lat = 0;
    while (busy_b && lat < 40) begin
      lat++;
      @(negedge slow_clock);
    end
  endtask

  initial begin
    int guard;
    resetb_a = 1'b0; new_round_a = 1'b0; dscore_a = '0; pscore_a = '0; pcard3_a = '0;
    resetb_b = 1'b0; new_round_b = 1'b0; dscore_b = '0; pscore_b = '0; pcard3_b = '0;
    @(negedge slow_clock);
    checkOutput("reset/busy", busy_a, 0);
    checkOutput("reset/round_cnt", rc_a, 0);
    checkOutput("reset/win_cnt", pwc_a, 0);
    checkOutput("reset/lights", {pwl_a, dwl_a}, 0);
    checkOutput("reset/strobes", {lp1_a, lp2_a, lp3_a, ld1_a, ld2_a, ld3_a}, 0);
    checkOutput("reset_b/round_cnt", rc_b, 0);
    resetb_a = 1'b1; resetb_b = 1'b1;
    repeat (3) @(negedge slow_clock);
    checkOutput("idle/busy", busy_a, 0);

    // ps packs {player1, player0}
    applyStimulus(4'd9, 8'h53, 8'h00, 1'b0);
    verifyRound("natural", 7, 0, 0, 0, 2'b00, 2'b11, 8'd1, 16'h0000);
    applyStimulus(4'd4, 8'h74, 8'h03, 1'b0);
    verifyRound("p0_draw_dealer_draw", 11, 1, 0, 1, 2'b11, 2'b01, 8'd2, 16'h0100);
    applyStimulus(4'd5, 8'h26, 8'h00, 1'b0);
    verifyRound("p0_stand_dealer_draw", 11, 0, 1, 1, 2'b01, 2'b10, 8'd3, 16'h0101);
    applyStimulus(4'd3, 8'h93, 8'h08, 1'b0);
    verifyRound("dealer_stands_on_8", 10, 1, 0, 0, 2'b11, 2'b01, 8'd4, 16'h0201);
    applyStimulus(4'd6, 8'h2B, 8'h00, 1'b0);
    verifyRound("score_above_9", 10, 0, 1, 0, 2'b01, 2'b10, 8'd5, 16'h0202);
    applyStimulus(4'd4, 8'h74, 8'h03, 1'b1);
    verifyRound("stray_new_round", 11, 1, 0, 1, 2'b11, 2'b01, 8'd6, 16'h0302);

    dscore_a = 4'd4; pscore_a = 8'h74; pcard3_a = 8'h03;
    @(negedge slow_clock); new_round_a = 1'b1;
    @(negedge slow_clock); new_round_a = 1'b0;
    guard = 0;
    while (!ld2_a && guard < 20) begin
      @(negedge slow_clock);
      guard++;
    end
    checkOutput("midreset/reach_d2", ld2_a, 1);
    @(negedge slow_clock);
    checkOutput("midreset/p3_strobe", lp3_a, 2'b01);
    resetb_a = 1'b0;
    #1;
    checkOutput("midreset/busy", busy_a, 0);
    checkOutput("midreset/strobes", {lp1_a, lp2_a, lp3_a, ld1_a, ld2_a, ld3_a}, 0);
    checkOutput("midreset/round_cnt", rc_a, 0);
    checkOutput("midreset/win_cnt", pwc_a, 0);
    @(negedge slow_clock); resetb_a = 1'b1;
    repeat (3) @(negedge slow_clock);
    checkOutput("postreset/busy", busy_a, 0);
    checkOutput("postreset/round_cnt", rc_a, 0);
    applyStimulus(4'd9, 8'h53, 8'h00, 1'b0);
    verifyRound("recovery", 7, 0, 0, 0, 2'b00, 2'b11, 8'd1, 16'h0000);

    runRoundB(4'd6, 4'd6);
    checkOutput("n1_tie/latency", lat, 7);
    checkOutput("n1_tie/third_cards", n_miss >= 0 ? {lp3_b, ld3_b} : 2'b11, 0);
    checkOutput("n1_tie/lights", {pwl_b, dwl_b}, 2'b11);
    checkOutput("n1_tie/round_cnt", rc_b, 1);
    checkOutput("n1_tie/win_cnt", pwc_b, 0);
    for (int k = 1; k <= 5; k++) begin
      runRoundB(4'd7, 4'd9);
      checkOutput($sformatf("n1_win%0d/lights", k), {pwl_b, dwl_b}, 2'b10);
      checkOutput($sformatf("n1_win%0d/win_cnt", k), pwc_b, (k > 3) ? 3 : k);
      checkOutput($sformatf("n1_win%0d/round_cnt", k), rc_b, (k + 1 > 3) ? 3 : k + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
